// File: rtl/router_sync_multi_pkg.sv
// Shared constants and helpers for the router destination synchronizer.
// Imported by the interface, the per-port timer and the top level.
package router_pkg;

  localparam int MAX_PORTS   = 8;
  localparam int DEF_TIMEOUT = 30;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/router_sync_multi_if.sv
// Handshake/status bundle between router FSM, FIFO array and synchronizer.
// slave faces the synchronizer, master faces the FSM/FIFO side.
interface router_sync_multi_if
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 3
);

  localparam int ADDR_W = clog2_min1(NUM_PORTS);

  logic                 detect_add;
  logic                 write_enb_reg;
  logic [ADDR_W-1:0]    data_in;
  logic [NUM_PORTS-1:0] read_enb;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] full;
  logic                 clr_status;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] write_enb;
  logic [NUM_PORTS-1:0] valid_out;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 addr_err;
  logic [NUM_PORTS-1:0] timeout_flag;

  modport slave (
    input  detect_add, write_enb_reg, data_in,
    input  read_enb, empty, full, clr_status,
    output fifo_full, write_enb, valid_out,
    output soft_reset, addr_err, timeout_flag
  );

  modport master (
    output detect_add, write_enb_reg, data_in,
    output read_enb, empty, full, clr_status,
    input  fifo_full, write_enb, valid_out,
    input  soft_reset, addr_err, timeout_flag
  );

endinterface

// File: rtl/router_sync_multi_timer.sv
// Per-port stall timer: one-cycle soft_reset after TIMEOUT stalled
// cycles, plus a sticky timeout_flag that survives until cleared.
module router_sync_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic empty,
  input  logic read_enb,
  input  logic clr_status,
  output logic soft_reset,
  output logic timeout_flag
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Count stalled cycles; any read or empty restarts the window.
  always_ff @(posedge clk) begin
    if (!rst || empty || read_enb) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (cnt == LAST) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + 1'b1;
      soft_reset <= 1'b0;
    end
  end

  // Sticky status; a pulse seen this cycle beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      timeout_flag <= 1'b0;
    end else if (soft_reset) begin
      timeout_flag <= 1'b1;
    end else if (clr_status) begin
      timeout_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync_multi.sv
// Destination synchronizer: latches header address, steers write enable,
// muxes the addressed full flag and runs per-port stall timers.
module router_sync_multi
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input logic                clk,
  input logic                rst,
  router_sync_multi_if.slave bus
);

  localparam int ADDR_W = clog2_min1(NUM_PORTS);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] NP = (ADDR_W + 1)'(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
    $error("router_sync_multi: NUM_PORTS out of range");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("router_sync_multi: TIMEOUT out of range");
  end

  logic [ADDR_W-1:0]    addr_q;
  logic                 addr_err_q;
  logic [NUM_PORTS-1:0] we;
  logic                 ff;

  // Capture destination on header; flag addresses past the last port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q     <= '0;
      addr_err_q <= 1'b0;
    end else if (bus.detect_add) begin
      addr_q     <= bus.data_in;
      addr_err_q <= ({1'b0, bus.data_in} >= NP);
    end
  end

  // Decode write enable and select full flag; bad address reads as free.
  always_comb begin
    we = '0;
    ff = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_q == ADDR_W'(i) && !addr_err_q) begin
        we[i] = bus.write_enb_reg;
        ff    = bus.full[i];
      end
    end
  end

  assign bus.write_enb = we;
  assign bus.fifo_full = ff;
  assign bus.addr_err  = addr_err_q;
  assign bus.valid_out = ~bus.empty;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timer
    router_sync_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_timer (
      .clk          (clk),
      .rst          (rst),
      .empty        (bus.empty[i]),
      .read_enb     (bus.read_enb[i]),
      .clr_status   (bus.clr_status),
      .soft_reset   (bus.soft_reset[i]),
      .timeout_flag (bus.timeout_flag[i])
    );
  end

endmodule

// File: tb/tb_router_sync_multi.sv
// Directed bench for router_sync_multi with a pulse scoreboard.
// Expected soft_reset pulses are queued at stall start and matched live.
module tb_router_sync_multi;

  localparam int NP = 3;
  localparam int TO = 30;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct {
    int         at;
    logic [2:0] mask;
  } exp_t;

  exp_t q[$];

  router_sync_multi_if #(.NUM_PORTS(NP)) bus ();

  router_sync_multi #(
    .NUM_PORTS (NP),
    .TIMEOUT   (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int at, input logic [2:0] mask);
    exp_t e;
    e.at   = at;
    e.mask = mask;
    q.push_back(e);
  endtask

  // Match every soft_reset pulse against the queued expectations.
  always @(negedge clk) begin
    if (q.size() > 0 && cyc > q[0].at) begin
      chk("pulse_missed", {29'd0, bus.soft_reset}, {29'd0, q[0].mask});
      void'(q.pop_front());
    end
    if (bus.soft_reset != '0) begin
      if (q.size() > 0 && q[0].at == cyc) begin
        chk("pulse_mask", {29'd0, bus.soft_reset}, {29'd0, q[0].mask});
        void'(q.pop_front());
      end else begin
        chk("pulse_unexpected", {29'd0, bus.soft_reset}, 32'd0);
      end
    end
  end

  initial begin
    int c;
    bus.detect_add    = 1'b0;
    bus.write_enb_reg = 1'b0;
    bus.data_in       = '0;
    bus.read_enb      = '0;
    bus.empty         = '1;
    bus.full          = 3'b001;
    bus.clr_status    = 1'b0;
    tick(2);
    rst = 1'b1;

    chk("rst_write_enb", {29'd0, bus.write_enb}, 32'd0);
    chk("rst_fifo_full", {31'd0, bus.fifo_full}, 32'd1);
    chk("rst_valid_out", {29'd0, bus.valid_out}, 32'd0);
    chk("rst_soft_reset", {29'd0, bus.soft_reset}, 32'd0);
    chk("rst_addr_err", {31'd0, bus.addr_err}, 32'd0);
    chk("rst_timeout_flag", {29'd0, bus.timeout_flag}, 32'd0);

    bus.full          = 3'b100;
    bus.detect_add    = 1'b1;
    bus.data_in       = 2'd2;
    bus.write_enb_reg = 1'b1;
    #1;
    chk("old_addr_we", {29'd0, bus.write_enb}, 32'h1);
    chk("old_addr_full", {31'd0, bus.fifo_full}, 32'd0);
    tick(1);
    bus.detect_add = 1'b0;
    chk("addr2_we", {29'd0, bus.write_enb}, 32'h4);
    chk("addr2_full", {31'd0, bus.fifo_full}, 32'd1);
    bus.full = 3'b011;
    #1;
    chk("addr2_full_track", {31'd0, bus.fifo_full}, 32'd0);

    bus.full       = 3'b111;
    bus.detect_add = 1'b1;
    bus.data_in    = 2'd3;
    tick(1);
    bus.detect_add = 1'b0;
    chk("bad_addr_err", {31'd0, bus.addr_err}, 32'd1);
    chk("bad_addr_we", {29'd0, bus.write_enb}, 32'd0);
    chk("bad_addr_full", {31'd0, bus.fifo_full}, 32'd0);
    tick(2);
    chk("bad_addr_hold", {31'd0, bus.addr_err}, 32'd1);

    bus.detect_add = 1'b1;
    bus.data_in    = 2'd1;
    tick(1);
    bus.detect_add = 1'b0;
    chk("addr1_err", {31'd0, bus.addr_err}, 32'd0);
    chk("addr1_we", {29'd0, bus.write_enb}, 32'h2);
    chk("addr1_full", {31'd0, bus.fifo_full}, 32'd1);
    bus.write_enb_reg = 1'b0;
    #1;
    chk("no_req_we", {29'd0, bus.write_enb}, 32'd0);
    bus.full  = 3'b000;
    bus.empty = 3'b010;
    #1;
    chk("valid_out", {29'd0, bus.valid_out}, 32'h5);
    bus.empty = 3'b111;
    tick(1);

    c = cyc;
    bus.empty = 3'b110;
    push(c + TO, 3'b001);
    push(c + 2 * TO, 3'b001);
    tick(2 * TO + 1);
    bus.empty = 3'b111;
    tick(1);
    chk("p0_flag", {29'd0, bus.timeout_flag}, 32'h1);
    bus.clr_status = 1'b1;
    tick(1);
    bus.clr_status = 1'b0;
    chk("p0_flag_clr", {29'd0, bus.timeout_flag}, 32'd0);

    c = cyc;
    bus.empty = 3'b101;
    tick(TO - 1);
    bus.read_enb = 3'b010;
    tick(1);
    bus.read_enb = 3'b000;
    push(c + 2 * TO, 3'b010);
    tick(TO);
    bus.empty = 3'b111;
    tick(2);
    chk("p1_flag", {29'd0, bus.timeout_flag}, 32'h2);
    bus.clr_status = 1'b1;
    tick(1);
    bus.clr_status = 1'b0;

    c = cyc;
    bus.empty = 3'b010;
    push(c + TO, 3'b101);
    tick(TO);
    chk("dual_pulse_now", {29'd0, bus.soft_reset}, 32'h5);
    bus.clr_status = 1'b1;
    bus.empty      = 3'b111;
    tick(1);
    bus.clr_status = 1'b0;
    chk("dual_flag_set_wins", {29'd0, bus.timeout_flag}, 32'h5);
    tick(1);

    bus.empty = 3'b110;
    tick(20);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    chk("midrst_flag", {29'd0, bus.timeout_flag}, 32'd0);
    push(cyc + TO, 3'b001);
    tick(TO);
    bus.empty = 3'b111;
    tick(2);
    chk("midrst_flag_after", {29'd0, bus.timeout_flag}, 32'h1);

    while (q.size() > 0) begin
      chk("pulse_never_seen", 32'd0, {29'd0, q[0].mask});
      void'(q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
